mem_req_sequencer: RTL and testbench

//  Upstream master for the single-port valid/ready memory. It buffers host read/write

---
 rtl/mem_req_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_mem_req_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: host-side master for a single-port valid/ready memory.
// Host requests are buffered in a small FIFO. They are issued to the memory one at a time.
// Each completion is reported on the rsp_* port.
// Optional build macro: MEM_REQ_TIMEOUT_EN. It bounds the wait for mem_ready_i. An expired
// wait drops the request and pulses err_o.
module mem_req_sequencer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                  clk_i,
  input  logic                  res_i,
  input  logic                  req_valid_i,
  input  logic                  req_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0]      req_wdata_i,
  output logic                  req_full_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_wr_rd_o,
  output logic [WIDTH-1:0]      rsp_rdata_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EntryW = 1 + ADDR_WIDTH + WIDTH;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e state_q, state_d;

  logic [EntryW-1:0]     fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  push, pop;
  logic                  head_wr_rd;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [WIDTH-1:0]      head_wdata;

  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_wr_rd_q, mem_wr_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_wr_rd_q, rsp_wr_rd_d;
  logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                  timeout_hit;

  // Full is decoded from the registered count, so a same-cycle pop never frees a slot early.
  assign req_full_o = (count_q == CntW'(FIFO_DEPTH));
  assign push       = req_valid_i && !req_full_o;
  assign {head_wr_rd, head_addr, head_wdata} = fifo_q[rd_ptr_q];

  // FIFO storage; contents need no reset because the pointers and count are cleared.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {req_wr_rd_i, req_addr_i, req_wdata_i};
    end
  end

  // FIFO pointer and occupancy next-state; pointers wrap naturally (depth is a power of 2).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer next-state and registered memory/response outputs.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    mem_valid_d = 1'b0;
    mem_wr_rd_d = mem_wr_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_wr_rd_d = rsp_wr_rd_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          mem_valid_d = 1'b1;
          mem_wr_rd_d = head_wr_rd;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_wdata;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        // A ready on the timeout cycle still completes the request.
        if (mem_ready_i) begin
          rsp_valid_d = 1'b1;
          rsp_wr_rd_d = mem_wr_rd_q;
          if (!mem_wr_rd_q) begin
            rsp_rdata_d = mem_rdata_i;
          end
          state_d = StIdle;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, FIFO control and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_rd_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_rd_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_valid_q <= mem_valid_d;
      mem_wr_rd_q <= mem_wr_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_rd_q <= rsp_wr_rd_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            err_q;

  assign timeout_hit = (state_q == StWait) && !mem_ready_i && (tmr_q == TmrW'(TIMEOUT - 1));
  assign err_o       = err_q;

  // Wait counter: cleared while entering WAIT, counts each WAIT cycle.
  always_comb begin
    tmr_d = tmr_q;
    if (state_q == StIssue) begin
      tmr_d = '0;
    end else if (state_q == StWait) begin
      tmr_d = tmr_q + TmrW'(1);
    end
  end

  // Timeout counter and error pulse registers.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= timeout_hit;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign err_o          = 1'b0;
`endif

  assign mem_valid_o = mem_valid_q;
  assign mem_wr_rd_o = mem_wr_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_wr_rd_o = rsp_wr_rd_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign busy_o      = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer: a behavioural memory drives the memory side. A queue-based model
// predicts every output each cycle, and directed sequences pin key literal values.
`timescale 1ns/1ps
module tb_mem_req_sequencer;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 8;

  logic                  clk = 1'b0;
  logic                  res = 1'b1;
  logic                  req_valid = 1'b0;
  logic                  req_wr_rd = 1'b0;
  logic [ADDR_WIDTH-1:0] req_addr = '0;
  logic [WIDTH-1:0]      req_wdata = '0;
  logic                  req_full;
  logic                  mem_valid, mem_wr_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata = '0;
  logic                  mem_ready = 1'b0;
  logic                  rsp_valid, rsp_wr_rd;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  busy, err;

  int n_tests = 0;
  int n_fail  = 0;
  int rsp_cnt = 0;

  mem_req_sequencer #(
    .WIDTH     (WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i      (clk),
    .res_i      (res),
    .req_valid_i(req_valid),
    .req_wr_rd_i(req_wr_rd),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_full_o (req_full),
    .mem_valid_o(mem_valid),
    .mem_wr_rd_o(mem_wr_rd),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready),
    .rsp_valid_o(rsp_valid),
    .rsp_wr_rd_o(rsp_wr_rd),
    .rsp_rdata_o(rsp_rdata),
    .busy_o     (busy),
    .err_o      (err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural memory (stimulus side) ----------------
  logic [WIDTH-1:0]      tbmem [16];
  bit                    pend;
  int                    mcnt;
  logic [ADDR_WIDTH-1:0] maddr;
  bit                    stall  = 1'b0;
  bit                    lat_en = 1'b0;

  initial forever begin
    @(posedge clk);
    if (res) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      foreach (tbmem[i]) tbmem[i] = '0;
      pend = 1'b0;
      mcnt = 0;
    end else begin
      mem_ready <= 1'b0;
      if (mem_valid) begin
        if (mem_wr_rd) tbmem[mem_addr] = mem_wdata;
        maddr = mem_addr;
        pend  = 1'b1;
        mcnt  = lat_en ? int'($urandom_range(0, 2)) : 0;
      end
      if (pend) begin
        if (mcnt == 0) begin
          if (!stall) begin
            mem_ready <= 1'b1;
            mem_rdata <= tbmem[maddr];
            pend = 1'b0;
          end
        end else begin
          mcnt--;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } req_t;

  req_t                  q[$];
  req_t                  cur;
  bit                    inflight = 1'b0;
  int                    t = 0;  // edges since the request was taken from the queue
  logic [WIDTH-1:0]      ref_mem [16];
  logic                  e_mem_valid = 0, e_mem_wr = 0, e_rsp_valid = 0, e_rsp_wr = 0;
  logic                  e_err = 0, e_full = 0, e_busy = 0;
  logic [ADDR_WIDTH-1:0] e_mem_addr = '0;
  logic [WIDTH-1:0]      e_mem_wdata = '0, e_rsp_rdata = '0;

  task automatic model_step();
    bit push;
    if (res) begin
      q.delete();
      inflight    = 1'b0;
      t           = 0;
      e_mem_valid = 0; e_mem_wr = 0; e_mem_addr = '0; e_mem_wdata = '0;
      e_rsp_valid = 0; e_rsp_wr = 0; e_rsp_rdata = '0; e_err = 0;
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else begin
      push        = req_valid && (q.size() < FIFO_DEPTH);
      e_mem_valid = 0;
      e_rsp_valid = 0;
      e_err       = 0;
      if (inflight) begin
        if (t == 0) begin
          t = 1;
        end else if (mem_ready) begin
          e_rsp_valid = 1;
          e_rsp_wr    = cur.wr;
          if (!cur.wr) e_rsp_rdata = ref_mem[cur.addr];
          inflight = 1'b0;
        end
`ifdef MEM_REQ_TIMEOUT_EN
        else if (t - 1 == int'(TIMEOUT) - 1) begin
          e_err    = 1;
          inflight = 1'b0;
        end
`endif
        else begin
          t++;
        end
      end else if (q.size() != 0) begin
        cur         = q.pop_front();
        inflight    = 1'b1;
        t           = 0;
        e_mem_valid = 1;
        e_mem_wr    = cur.wr;
        e_mem_addr  = cur.addr;
        e_mem_wdata = cur.data;
        if (cur.wr) ref_mem[cur.addr] = cur.data;
      end
      if (push) q.push_back(req_t'{req_wr_rd, req_addr, req_wdata});
    end
    e_full = (q.size() == FIFO_DEPTH);
    e_busy = inflight || (q.size() != 0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) rsp_cnt++;
      check("mem_valid", mem_valid, e_mem_valid);
      check("mem_wr_rd", mem_wr_rd, e_mem_wr);
      check("mem_addr", mem_addr, e_mem_addr);
      if (e_mem_wr) check("mem_wdata", mem_wdata, e_mem_wdata);
      check("rsp_valid", rsp_valid, e_rsp_valid);
      check("rsp_wr_rd", rsp_wr_rd, e_rsp_wr);
      check("rsp_rdata", rsp_rdata, e_rsp_rdata);
      check("req_full", req_full, e_full);
      check("busy", busy, e_busy);
      check("err", err, e_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
  endtask

  // Holds a request until accepted; returns 1 time unit after the accepting edge.
  task automatic push(input logic wr, input logic [ADDR_WIDTH-1:0] a, input logic [WIDTH-1:0] d);
    logic f;
    int   n;
    n = 0;
    req_valid = 1'b1; req_wr_rd = wr; req_addr = a; req_wdata = d;
    do begin
      f = req_full;
      @(posedge clk); #1;
      n++;
    end while (f && n < 200);
    check("push_accept", f, 1'b0);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idle_bound", (n < 300), 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- directed and random sequences ----------------
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    @(negedge clk);
    check("reset_mem_valid", mem_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(posedge clk); #1;

    // Write 5 <- A5 then read it back, with fixed three-cycle latency.
    push(1'b1, 4'd5, 8'hA5);
    @(posedge clk); #1;
    check("t1_issue_valid", mem_valid, 1'b1);
    check("t1_issue_addr", mem_addr, 4'd5);
    repeat (2) @(posedge clk);
    #1;
    check("t1_wr_rsp_valid", rsp_valid, 1'b1);
    check("t1_wr_rsp_type", rsp_wr_rd, 1'b1);
    push(1'b0, 4'd5, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("t1_rd_rsp_valid", rsp_valid, 1'b1);
    check("t1_rd_rsp_type", rsp_wr_rd, 1'b0);
    check("t1_rd_rdata", rsp_rdata, 8'hA5);
    wait_idle();

    // Read all addresses after reset.
    do_reset();
    rsp_cnt = 0;
    for (int a = 0; a < 16; a++) push(1'b0, ADDR_WIDTH'(a), WIDTH'($urandom));
    wait_idle();
    check("t2_rsp_count", rsp_cnt, 16);
    check("t2_rdata_zero", rsp_rdata, 8'h00);

    // Fill the FIFO behind a stalled write; the last two back-to-back writes are dropped.
    stall = 1'b1;
    push(1'b1, 4'd0, 8'h10);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_wr_rd = 1'b1;
      req_addr = ADDR_WIDTH'(i + 1); req_wdata = WIDTH'(8'h20 + i);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("t3_full", req_full, 1'b1);
    stall = 1'b0;
    wait_idle();
    for (int a = 1; a <= 6; a++) begin
      push(1'b0, ADDR_WIDTH'(a), 8'h00);
      wait_idle();
      check("t3_readback", rsp_rdata, (a <= 4) ? 32'(8'h20 + a - 1) : 32'h0);
    end

    // Back-to-back writes while idle: the fifth push coincides with a pop at count 3.
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_wr_rd = 1'b1;
      req_addr = ADDR_WIDTH'(8 + i); req_wdata = WIDTH'(8'h30 + i);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("t4_not_full", req_full, 1'b0);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      push(1'b0, ADDR_WIDTH'(8 + i), 8'h00);
      wait_idle();
      check("t4_readback", rsp_rdata, 32'(8'h30 + i));
    end

    // Reset while a read is waiting for ready.
    rsp_cnt = 0;
    stall   = 1'b1;
    push(1'b0, 4'd8, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    res = 1'b1;
    @(posedge clk); #1;
    res   = 1'b0;
    stall = 1'b0;
    check("t5_mem_valid", mem_valid, 1'b0);
    check("t5_mem_addr", mem_addr, 4'd0);
    check("t5_rsp_valid", rsp_valid, 1'b0);
    check("t5_rsp_rdata", rsp_rdata, 8'h00);
    check("t5_busy", busy, 1'b0);
    check("t5_full", req_full, 1'b0);
    check("t5_err", err, 1'b0);
    push(1'b0, 4'd9, 8'h00);
    wait_idle();
    check("t5_rsp_count", rsp_cnt, 1);

`ifdef MEM_REQ_TIMEOUT_EN
    // Timeout: with ready held low, err fires 8 cycles after entering WAIT.
    rsp_cnt = 0;
    stall   = 1'b1;
    push(1'b0, 4'd3, 8'h00);
    push(1'b1, 4'd4, 8'h44);
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_err_delay", n, 9);
    check("t6_no_rsp", rsp_cnt, 0);
    @(posedge clk); #1;
    check("t6_next_issue", mem_valid, 1'b1);
    check("t6_next_addr", mem_addr, 4'd4);
    stall = 1'b0;
    wait_idle();
`endif

    // Randomized traffic with variable memory latency and rare resets.
    lat_en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      res       = ($urandom_range(0, 249) == 0);
      req_valid = $urandom_range(0, 1) == 1;
      req_wr_rd = $urandom_range(0, 1) == 1;
      req_addr  = ADDR_WIDTH'($urandom);
      req_wdata = WIDTH'($urandom);
      @(posedge clk); #1;
    end
    res       = 1'b0;
    req_valid = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
